// File: rtl/link_partner.sv
// Far end of the DMG link-cable serial port: exchanges one byte per transfer, MSB first,
// either following the DMG's SCK (slave) or generating SCK itself (master).
module link_partner #(
  parameter int          HALF_PERIOD = 4,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       master_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic       sck_in,
  output logic       sck_out,
  output logic       sck_oe,
  input  logic       si,
  output logic       so
);

  localparam int HW = $clog2(HALF_PERIOD + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, M_LOW, M_HIGH} state_t;

  state_t        state, next_state;
  logic          sck_s1, sck_s2, sck_d;
  logic          si_s1, si_s2;
  logic          buf_full;
  logic [7:0]    buf_data;
  logic [7:0]    shreg;
  logic [3:0]    cnt;
  logic [HW-1:0] hcnt;

  logic       sck_fall, sck_rise, half_done, accept;
  logic       commit, start_master, shift_en, so_load, done;
  logic [7:0] commit_byte, done_byte;

  assign sck_fall    = sck_d & ~sck_s2;
  assign sck_rise    = ~sck_d & sck_s2;
  assign half_done   = (hcnt == HW'(HALF_PERIOD - 1));
  assign accept      = tx_valid & ~buf_full;
  assign tx_ready    = ~buf_full;
  assign busy        = (state != IDLE);
  assign commit_byte = buf_full ? buf_data : IDLE_BYTE;
  // Slave completes on the 8th rising edge itself, so the last bit is folded in here.
  assign done_byte   = (state == SHIFT) ? {shreg[6:0], si_s2} : shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (master_en) begin
          if (buf_full) next_state = M_LOW;
        end else if (sck_fall) begin
          next_state = SHIFT;
        end
      end
      SHIFT:   if (sck_rise && cnt == 4'd7) next_state = IDLE;
      M_LOW:   if (half_done) next_state = M_HIGH;
      M_HIGH:  if (half_done) next_state = (cnt == 4'd8) ? IDLE : M_LOW;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    commit       = (state == IDLE) && (next_state != IDLE);
    start_master = (state == IDLE) && (next_state == M_LOW);
    shift_en     = ((state == SHIFT) && sck_rise) || ((state == M_LOW) && half_done);
    so_load      = ((state == SHIFT) && sck_fall && cnt != 4'd0) ||
                   ((state == M_HIGH) && half_done && cnt != 4'd8);
    done         = ((state == SHIFT) && sck_rise && cnt == 4'd7) ||
                   ((state == M_HIGH) && half_done && cnt == 4'd8);
  end

  // Pin synchronisers; SCK and SI both idle high on the cable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1 <= 1'b1;
      sck_s2 <= 1'b1;
      sck_d  <= 1'b1;
      si_s1  <= 1'b1;
      si_s2  <= 1'b1;
    end else begin
      sck_s1 <= sck_in;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      si_s1  <= si;
      si_s2  <= si_s1;
    end
  end

  // A host byte accepted on a commit cycle with an empty buffer stays buffered for the next transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= 8'h00;
    end else begin
      if (commit) buf_full <= 1'b0;
      if (accept) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= 8'h00;
      cnt      <= 4'd0;
      hcnt     <= '0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      so       <= 1'b1;
      sck_out  <= 1'b1;
      sck_oe   <= 1'b0;
    end else begin
      rx_valid <= done;
      if (done) rx_data <= done_byte;

      if (commit) begin
        shreg <= commit_byte;
        so    <= commit_byte[7];
        cnt   <= 4'd0;
        hcnt  <= '0;
        if (start_master) begin
          sck_oe  <= 1'b1;
          sck_out <= 1'b0;
        end
      end else if (state == IDLE) begin
        so <= buf_full ? buf_data[7] : IDLE_BYTE[7];
      end else begin
        if (shift_en) begin
          shreg <= {shreg[6:0], si_s2};
          cnt   <= cnt + 4'd1;
        end
        if (so_load) so <= shreg[7];
        if (state == M_LOW || state == M_HIGH) begin
          hcnt <= half_done ? '0 : hcnt + HW'(1);
        end
        if (state == M_LOW && half_done) begin
          sck_out <= 1'b1;
        end else if (state == M_HIGH && half_done) begin
          sck_out <= (cnt == 4'd8);
          if (cnt == 4'd8) sck_oe <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_link_partner.sv
// Self-checking bench for link_partner: a DMG-side model drives SCK/SI (slave) or follows
// the partner's SCK (master); expected bytes come from a one-entry buffer model.
module tb_link_partner;

  logic       clk = 1'b0;
  logic       reset, master_en, tx_valid, sck_in, si;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, sck_out, sck_oe, so;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int oe_cnt = 0;

  logic       mbuf_full = 1'b0;
  logic [7:0] mbuf = 8'h00;

  link_partner #(.HALF_PERIOD(4), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .master_en(master_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sck_in(sck_in), .sck_out(sck_out), .sck_oe(sck_oe),
    .si(si), .so(so)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (sck_oe)   oe_cnt <= oe_cnt + 1;
  end

  task automatic load(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL load_timeout tx_ready=%0b want 1", tx_ready);
    end else begin
      tx_data = b; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      mbuf = b; mbuf_full = 1'b1;
    end
  endtask

  task automatic model_commit(output logic [7:0] e);
    e = mbuf_full ? mbuf : 8'hFF;
    mbuf_full = 1'b0;
  endtask

  // One DMG-clocked bit: SI changes with SCK low, SO is read just before SCK rises.
  task automatic slave_bit(input logic b, output logic sb);
    sck_in = 1'b0; si = b;
    repeat (8) @(negedge clk);
    sb = so;
    sck_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic slave_xfer(input logic [7:0] si_byte, input int load_at, input logic [7:0] load_byte,
                            output logic [7:0] so_byte, output logic [7:0] exp_so);
    logic sb;
    model_commit(exp_so);
    for (int i = 0; i < 8; i++) begin
      if (i == load_at) load(load_byte);
      slave_bit(si_byte[7-i], sb);
      so_byte[7-i] = sb;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic master_xfer(input logic [7:0] si_byte, output logic [7:0] so_byte, output int falls,
                             output int bad_period, output int low_cycles, output int timeout);
    logic prev;
    int   last_fall, rx0;
    rx0 = rx_cnt; falls = 0; bad_period = 0; low_cycles = 0; timeout = 1; last_fall = 0;
    so_byte = 8'h00;
    prev = sck_out;
    master_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (t == 2) master_en = 1'b0;
      if (!sck_out) low_cycles++;
      if (prev && !sck_out) begin
        if (falls > 0 && (t - last_fall) != 8) bad_period++;
        last_fall = t;
        if (falls < 8) si = si_byte[7-falls];
        falls++;
      end
      if (!prev && sck_out && falls >= 1 && falls <= 8) so_byte[8-falls] = so;
      prev = sck_out;
      if (rx_cnt != rx0) begin
        timeout = 0;
        break;
      end
    end
    master_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; master_en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; sck_in = 1'b1; si = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({tx_ready, rx_data, rx_valid, busy, sck_oe, sck_out, so} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got tx_ready=%0b rx_data=%h rx_valid=%0b busy=%0b sck_oe=%0b sck_out=%0b so=%0b want 1 00 0 0 0 1 1",
               tx_ready, rx_data, rx_valid, busy, sck_oe, sck_out, so);
    end
  endtask

  task automatic test_slave_basic;
    logic [7:0] sob, exp;
    int rx0, oe0;
    load(8'hA5);
    repeat (2) @(negedge clk);
    checks++;
    if (so !== 1'b1) begin errors++; $display("FAIL idle_so got %0b want 1", so); end
    rx0 = rx_cnt; oe0 = oe_cnt;
    slave_xfer(8'h3C, -1, 8'h00, sob, exp);
    checks++;
    if (sob !== 8'hA5) begin errors++; $display("FAIL slave_so got %h want a5", sob); end
    checks++;
    if (rx_data !== 8'h3C) begin errors++; $display("FAIL slave_rx got %h want 3c", rx_data); end
    checks++;
    if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL slave_rx_pulses got %0d want 1", rx_cnt - rx0); end
    checks++;
    if (busy !== 1'b0 || oe_cnt != oe0) begin
      errors++; $display("FAIL slave_end got busy=%0b oe_cycles=%0d want 0 0", busy, oe_cnt - oe0);
    end
  endtask

  task automatic test_slave_idle_byte;
    logic [7:0] sob, exp;
    slave_xfer(8'h00, -1, 8'h00, sob, exp);
    checks++;
    if (sob !== 8'hFF) begin errors++; $display("FAIL idle_byte_so got %h want ff", sob); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL idle_byte_rx got %h want 00", rx_data); end
  endtask

  task automatic test_master;
    logic [7:0] sob, exp;
    int falls, bad, low, tmo;
    load(8'h81);
    model_commit(exp);
    master_xfer(8'h7E, sob, falls, bad, low, tmo);
    checks++;
    if (tmo != 0) begin errors++; $display("FAIL master_timeout got no rx_valid want completion"); end
    checks++;
    if (falls != 8 || bad != 0 || low != 32) begin
      errors++; $display("FAIL master_sck got falls=%0d bad_periods=%0d low_cycles=%0d want 8 0 32", falls, bad, low);
    end
    checks++;
    if (sob !== exp) begin errors++; $display("FAIL master_so got %h want %h", sob, exp); end
    checks++;
    if (rx_data !== 8'h7E) begin errors++; $display("FAIL master_rx got %h want 7e", rx_data); end
    checks++;
    if (sck_oe !== 1'b0 || sck_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL master_end got sck_oe=%0b sck_out=%0b busy=%0b want 0 1 0", sck_oe, sck_out, busy);
    end
  endtask

  task automatic test_master_empty;
    int oe0;
    oe0 = oe_cnt;
    master_en = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || oe_cnt != oe0) begin
      errors++; $display("FAIL master_empty got busy=%0b oe_cycles=%0d want 0 0", busy, oe_cnt - oe0);
    end
    master_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] sob, exp;
    load(8'h11);
    slave_xfer(8'h55, 2, 8'h22, sob, exp);
    checks++;
    if (sob !== 8'h11) begin errors++; $display("FAIL b2b_first_so got %h want 11", sob); end
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held got %0b want 0", tx_ready); end
    slave_xfer(8'hAA, -1, 8'h00, sob, exp);
    checks++;
    if (sob !== 8'h22) begin errors++; $display("FAIL b2b_second_so got %h want 22", sob); end
    checks++;
    if (tx_ready !== 1'b1 || rx_data !== 8'hAA) begin
      errors++; $display("FAIL b2b_end got tx_ready=%0b rx=%h want 1 aa", tx_ready, rx_data);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] sob, exp, sib;
    logic sb;
    int rx0;
    load(8'h3C);
    model_commit(exp);
    rx0 = rx_cnt;
    for (int i = 0; i < 4; i++) slave_bit(1'b0, sb);
    load(8'h99);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mbuf_full = 1'b0;
    checks++;
    if ({tx_ready, rx_data, rx_valid, busy, sck_oe, sck_out, so} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got tx_ready=%0b rx_data=%h rx_valid=%0b busy=%0b sck_oe=%0b sck_out=%0b so=%0b want 1 00 0 0 0 1 1",
               tx_ready, rx_data, rx_valid, busy, sck_oe, sck_out, so);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_cnt != rx0) begin errors++; $display("FAIL reset_no_rx got %0d pulses want 0", rx_cnt - rx0); end
    sib = 8'($urandom);
    slave_xfer(sib, -1, 8'h00, sob, exp);
    checks++;
    if (sob !== 8'hFF || rx_data !== sib) begin
      errors++; $display("FAIL reset_next_xfer got so=%h rx=%h want ff %h", sob, rx_data, sib);
    end
  endtask

  task automatic test_mode_change;
    logic [7:0] exp, sob, sib;
    logic sb;
    int oe0, rx0;
    sib = 8'($urandom);
    load(8'hC3);
    model_commit(exp);
    oe0 = oe_cnt; rx0 = rx_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) master_en = 1'b1;
      slave_bit(sib[7-i], sb);
      sob[7-i] = sb;
    end
    repeat (4) @(negedge clk);
    master_en = 1'b0;
    checks++;
    if (oe_cnt != oe0) begin errors++; $display("FAIL mode_change_oe got %0d oe cycles want 0", oe_cnt - oe0); end
    checks++;
    if (sob !== exp || rx_data !== sib || rx_cnt - rx0 != 1) begin
      errors++; $display("FAIL mode_change_xfer got so=%h rx=%h pulses=%0d want %h %h 1", sob, rx_data, rx_cnt - rx0, exp, sib);
    end
  endtask

  task automatic test_random;
    logic [7:0] sob, exp, sib, txb;
    int falls, bad, low, tmo, rx0;
    for (int r = 0; r < 8; r++) begin
      sib = 8'($urandom);
      txb = 8'($urandom);
      rx0 = rx_cnt;
      if ($urandom_range(0, 1) == 1) begin
        load(txb);
        model_commit(exp);
        master_xfer(sib, sob, falls, bad, low, tmo);
        checks++;
        if (tmo != 0 || falls != 8 || bad != 0) begin
          errors++; $display("FAIL rand_master_sck r=%0d got timeout=%0d falls=%0d bad=%0d want 0 8 0", r, tmo, falls, bad);
        end
      end else begin
        if ($urandom_range(0, 1) == 1) load(txb);
        slave_xfer(sib, -1, 8'h00, sob, exp);
      end
      checks++;
      if (sob !== exp || rx_data !== sib || rx_cnt - rx0 != 1) begin
        errors++; $display("FAIL rand_xfer r=%0d got so=%h rx=%h pulses=%0d want %h %h 1", r, sob, rx_data, rx_cnt - rx0, exp, sib);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slave_basic();
    test_slave_idle_byte();
    test_master();
    test_master_empty();
    test_back_to_back();
    test_reset_mid();
    test_mode_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
